// File: rtl/eth_frame_wrap.sv
// -----------------------------------------------------------------------------
// eth_frame_wrap
//   Wraps one byte-wide L3 payload (ARP / IPv4) into an Ethernet II frame:
//   14-byte header (dest MAC, src MAC, EtherType) followed by the payload,
//   zero-padded up to MIN_FRAME bytes (FCS excluded). Feeds the MAC/FCS stage.
//
// Ports
//   s_axis_aclk, s_axis_areset : clock, async active-high reset
//   eth_destMac/srcMac/type    : header fields, latched when a frame starts
//   s_axis_*                   : payload stream in (tuser = first byte)
//   m_axis_*                   : frame stream out (tuser = first header byte,
//                                tlast = final byte including pad)
//   frame_busy                 : high whenever a frame is in progress
// -----------------------------------------------------------------------------
module eth_frame_wrap #(
  parameter int MIN_FRAME = 60,
  parameter int CNT_W     = 11
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [47:0] eth_destMac,
  input  logic [47:0] eth_srcMac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tuser,
  output logic        m_axis_tlast,
  output logic        frame_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    PAD     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_FRAME);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(13);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [47:0]      dst_q, dst_d, src_q, src_d;
  logic [15:0]      type_q, type_d;
  logic [7:0]       tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tuser_q, tuser_d;
  logic             tlast_q, tlast_d;
  logic             busy_q, busy_d;
  logic             out_free;

  // Header byte selector: MACs go out most-significant byte first.
  function automatic logic [7:0] hdr_byte(input logic [3:0]  idx,
                                          input logic [47:0] dst,
                                          input logic [47:0] src,
                                          input logic [15:0] typ);
    logic [7:0] b;
    case (idx)
      4'd0:    b = dst[47:40];
      4'd1:    b = dst[39:32];
      4'd2:    b = dst[31:24];
      4'd3:    b = dst[23:16];
      4'd4:    b = dst[15:8];
      4'd5:    b = dst[7:0];
      4'd6:    b = src[47:40];
      4'd7:    b = src[39:32];
      4'd8:    b = src[31:24];
      4'd9:    b = src[23:16];
      4'd10:   b = src[15:8];
      4'd11:   b = src[7:0];
      4'd12:   b = typ[15:8];
      4'd13:   b = typ[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // The output register can take a new byte when empty or being drained.
  assign out_free      = ~tvalid_q | m_axis_tready;
  // Saturating increment so oversize frames never wrap the length count.
  assign cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_ONE);
  assign s_axis_tready = (state_q == PAYLOAD) & out_free;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_busy    = busy_q;

  // Next-state and output-register load logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dst_d    = dst_q;
    src_d    = src_q;
    type_d   = type_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;

    // A byte leaving the register without a replacement empties it.
    if (out_free) begin
      tvalid_d = 1'b0;
      tuser_d  = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end

    case (state_q)
      IDLE: begin
        // The SOF byte is only observed here; PAYLOAD consumes it later.
        if (s_axis_tvalid & s_axis_tuser) begin
          dst_d   = eth_destMac;
          src_d   = eth_srcMac;
          type_d  = eth_type;
          cnt_d   = CNT_ZERO;
          state_d = HEADER;
        end else begin
          state_d = IDLE;
        end
      end

      HEADER: begin
        if (out_free) begin
          tdata_d  = hdr_byte(cnt_q[3:0], dst_q, src_q, type_q);
          tvalid_d = 1'b1;
          tuser_d  = (cnt_q == CNT_ZERO);
          tlast_d  = 1'b0;
          cnt_d    = cnt_inc;
          state_d  = (cnt_q == HDR_LAST) ? PAYLOAD : HEADER;
        end else begin
          state_d  = HEADER;
        end
      end

      PAYLOAD: begin
        if (s_axis_tvalid & out_free) begin
          tdata_d  = s_axis_tdata;
          tvalid_d = 1'b1;
          tuser_d  = 1'b0;
          cnt_d    = cnt_inc;
          if (s_axis_tlast) begin
            // cnt_inc already includes this byte.
            if (cnt_inc >= MIN_CNT) begin
              tlast_d = 1'b1;
              state_d = IDLE;
            end else begin
              tlast_d = 1'b0;
              state_d = PAD;
            end
          end else begin
            tlast_d = 1'b0;
            state_d = PAYLOAD;
          end
        end else begin
          state_d = PAYLOAD;
        end
      end

      PAD: begin
        if (out_free) begin
          tdata_d  = 8'h00;
          tvalid_d = 1'b1;
          tuser_d  = 1'b0;
          cnt_d    = cnt_inc;
          if (cnt_inc >= MIN_CNT) begin
            tlast_d = 1'b1;
            state_d = IDLE;
          end else begin
            tlast_d = 1'b0;
            state_d = PAD;
          end
        end else begin
          state_d = PAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counter, latched header fields and output register.
  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      dst_q    <= 48'h0;
      src_q    <= 48'h0;
      type_q   <= 16'h0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dst_q    <= dst_d;
      src_q    <= src_d;
      type_q   <= type_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_eth_frame_wrap.sv
module tb_eth_frame_wrap;

  localparam int MIN_FRAME = 60;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] dmac, smac;
  logic [15:0] etype;
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tready, s_tuser, s_tlast;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tready, m_tuser, m_tlast;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  int rdy_pct = 100;
  int cyc     = 0;
  int stab_viol = 0;
  int rdy_viol  = 0;

  logic [7:0] got_d[$];
  bit         got_u[$];
  bit         got_l[$];
  int         got_c[$];
  logic [7:0] exp_d[$];
  bit         exp_u[$];
  bit         exp_l[$];

  eth_frame_wrap #(.MIN_FRAME(MIN_FRAME), .CNT_W(11)) dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .eth_destMac   (dmac),
    .eth_srcMac    (smac),
    .eth_type      (etype),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tuser  (s_tuser),
    .s_axis_tlast  (s_tlast),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .frame_busy    (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready, random with rdy_pct duty.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  end

  // Output monitor: records handshakes, checks hold-while-stalled.
  initial begin
    logic       pv;
    logic [7:0] pd;
    logic       pu, pl;
    pv = 1'b0; pd = 8'h00; pu = 1'b0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv) begin
          if (m_tvalid !== 1'b1 || m_tdata !== pd || m_tuser !== pu || m_tlast !== pl)
            stab_viol++;
        end
        if (s_tready === 1'b1 && busy !== 1'b1) rdy_viol++;
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
          got_d.push_back(m_tdata);
          got_u.push_back(m_tuser);
          got_l.push_back(m_tlast);
          got_c.push_back(cyc);
        end
        pv = m_tvalid & ~m_tready;
        pd = m_tdata; pu = m_tuser; pl = m_tlast;
      end
    end
  end

  function automatic byte_q_t rand_payload(input int n);
    byte_q_t q;
    for (int k = 0; k < n; k++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference frame: header, payload, zero pad up to MIN_FRAME.
  function automatic void add_expected(input logic [47:0] d, input logic [47:0] s,
                                       input logic [15:0] t, input byte_q_t pl);
    logic [7:0] f[$];
    for (int k = 5; k >= 0; k--) f.push_back(d[k*8 +: 8]);
    for (int k = 5; k >= 0; k--) f.push_back(s[k*8 +: 8]);
    f.push_back(t[15:8]);
    f.push_back(t[7:0]);
    foreach (pl[k]) f.push_back(pl[k]);
    while (f.size() < MIN_FRAME) f.push_back(8'h00);
    foreach (f[k]) begin
      exp_d.push_back(f[k]);
      exp_u.push_back(k == 0);
      exp_l.push_back(k == f.size() - 1);
    end
  endfunction

  function automatic int first_diff();
    int n;
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int k = 0; k < n; k++)
      if (got_d[k] !== exp_d[k] || got_u[k] !== exp_u[k] || got_l[k] !== exp_l[k]) return k;
    if (got_d.size() != exp_d.size()) return n;
    return -1;
  endfunction

  task automatic clear_all();
    got_d.delete(); got_u.delete(); got_l.delete(); got_c.delete();
    exp_d.delete(); exp_u.delete(); exp_l.delete();
    stab_viol = 0;
    rdy_viol  = 0;
  endtask

  // Drives one payload; leaves tvalid as-is afterwards so frames can abut.
  task automatic send_payload(input byte_q_t pl, input int gap_pct,
                              input logic [47:0] d, input logic [47:0] s,
                              input logic [15:0] t, output int sent);
    int i, guard;
    bit acc, holding;
    i = 0; guard = 0; holding = 0;
    dmac = d; smac = s; etype = t;
    while (i < pl.size() && guard < 20000 && !rst) begin
      if (!holding) begin
        if (i > 0 && $urandom_range(0, 99) < gap_pct) begin
          s_tvalid = 1'b0;
        end else begin
          s_tvalid = 1'b1;
          s_tdata  = pl[i];
          s_tuser  = (i == 0);
          s_tlast  = (i == pl.size() - 1);
          holding  = 1;
        end
      end
      @(negedge clk);
      acc = s_tvalid && s_tready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        i++;
        holding = 0;
        if (i == 1) begin
          dmac  = {16'($urandom), $urandom};
          smac  = {16'($urandom), $urandom};
          etype = 16'($urandom);
        end
      end
    end
    sent = i;
  endtask

  task automatic wait_out(input int n);
    int g;
    g = 0;
    while (got_d.size() < n && g < 5000) begin
      @(posedge clk);
      g++;
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_total++;
    if ({m_tvalid, m_tuser, m_tlast} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {m_tvalid, m_tuser, m_tlast});
    else n_pass++;
    n_total++;
    if (m_tdata !== 8'h00) $display("FAIL reset_data: got %h want 00", m_tdata);
    else n_pass++;
    n_total++;
    if (s_tready !== 1'b0) $display("FAIL reset_s_tready: got %b want 0", s_tready);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_arp();
    byte_q_t pl;
    int sent, dff;
    clear_all();
    rdy_pct = 100;
    pl = rand_payload(28);
    add_expected(48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0806, pl);
    send_payload(pl, 0, 48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0806, sent);
    s_tvalid = 1'b0;
    wait_out(60);
    n_total++;
    if (sent != 28) $display("FAIL arp_accepted: got %0d want 28", sent);
    else n_pass++;
    n_total++;
    if (got_d.size() != 60) $display("FAIL arp_length: got %0d want 60", got_d.size());
    else n_pass++;
    dff = first_diff();
    n_total++;
    if (dff !== -1) $display("FAIL arp_content: first diff at byte %0d (got %0d bytes)", dff, got_d.size());
    else n_pass++;
  endtask

  task automatic test_min_boundary();
    byte_q_t pa, pb;
    int sa, sb, dff;
    logic [47:0] d, s;
    clear_all();
    rdy_pct = 100;
    d = 48'h0011_2233_4455;
    s = 48'h6677_8899_AABB;
    pa = rand_payload(46);
    pb = rand_payload(47);
    add_expected(d, s, 16'h0800, pa);
    send_payload(pa, 0, d, s, 16'h0800, sa);
    s_tvalid = 1'b0;
    wait_out(60);
    n_total++;
    if (got_d.size() != 60) $display("FAIL len46: got %0d want 60", got_d.size());
    else n_pass++;
    add_expected(s, d, 16'h0800, pb);
    send_payload(pb, 0, s, d, 16'h0800, sb);
    s_tvalid = 1'b0;
    wait_out(121);
    n_total++;
    if (got_d.size() != 121) $display("FAIL len47: got %0d want 121 total", got_d.size());
    else n_pass++;
    dff = first_diff();
    n_total++;
    if (dff !== -1) $display("FAIL boundary_content: first diff at byte %0d", dff);
    else n_pass++;
    n_total++;
    if (sa + sb != 93) $display("FAIL boundary_accepted: got %0d want 93", sa + sb);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    byte_q_t pl;
    int sent, dff;
    clear_all();
    rdy_pct = 50;
    pl = rand_payload(28);
    add_expected(48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0806, pl);
    send_payload(pl, 0, 48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0806, sent);
    s_tvalid = 1'b0;
    wait_out(60);
    dff = first_diff();
    n_total++;
    if (dff !== -1) $display("FAIL bp_content: first diff at byte %0d (got %0d bytes)", dff, got_d.size());
    else n_pass++;
    n_total++;
    if (stab_viol != 0) $display("FAIL bp_hold_stable: got %0d violations want 0", stab_viol);
    else n_pass++;
    rdy_pct = 100;
  endtask

  task automatic test_src_gaps();
    byte_q_t pl;
    int sent, dff;
    clear_all();
    rdy_pct = 100;
    pl = rand_payload(28);
    add_expected(48'h0200_0000_0001, 48'h0200_0000_0002, 16'h0806, pl);
    send_payload(pl, 40, 48'h0200_0000_0001, 48'h0200_0000_0002, 16'h0806, sent);
    s_tvalid = 1'b0;
    wait_out(60);
    dff = first_diff();
    n_total++;
    if (dff !== -1) $display("FAIL gaps_content: first diff at byte %0d (got %0d bytes)", dff, got_d.size());
    else n_pass++;
    n_total++;
    if (rdy_viol != 0) $display("FAIL gaps_idle_ready: got %0d cycles want 0", rdy_viol);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    byte_q_t pa, pb;
    int sa, sb, dff, gap;
    clear_all();
    rdy_pct = 100;
    pa = rand_payload(28);
    pb = rand_payload(28);
    add_expected(48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0806, pa);
    add_expected(48'hFFFF_FFFF_FFFF, 48'h000A_35AA_BBCC, 16'h0806, pb);
    send_payload(pa, 0, 48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0806, sa);
    send_payload(pb, 0, 48'hFFFF_FFFF_FFFF, 48'h000A_35AA_BBCC, 16'h0806, sb);
    s_tvalid = 1'b0;
    wait_out(120);
    dff = first_diff();
    n_total++;
    if (dff !== -1) $display("FAIL b2b_content: first diff at byte %0d (got %0d bytes)", dff, got_d.size());
    else n_pass++;
    gap = (got_c.size() > 60) ? (got_c[60] - got_c[59]) : 9999;
    n_total++;
    if (gap > 2) $display("FAIL b2b_bubble: got %0d cycles between tlast and tuser want <= 2", gap);
    else n_pass++;
    n_total++;
    if (sa + sb != 56) $display("FAIL b2b_accepted: got %0d want 56", sa + sb);
    else n_pass++;
  endtask

  task automatic test_idle_no_sof();
    int hi;
    clear_all();
    hi = 0;
    s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 8'h55;
    repeat (30) begin
      @(negedge clk);
      if (s_tready === 1'b1 || busy === 1'b1) hi++;
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    n_total++;
    if (hi != 0) $display("FAIL nosof_ready_busy: got %0d cycles want 0", hi);
    else n_pass++;
    n_total++;
    if (got_d.size() != 0) $display("FAIL nosof_output: got %0d bytes want 0", got_d.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    byte_q_t pl;
    int sent, dff, g, lasts;
    clear_all();
    rdy_pct = 100;
    pl = rand_payload(28);
    fork
      send_payload(pl, 0, 48'h0A0B_0C0D_0E0F, 48'h1112_1314_1516, 16'h0800, sent);
      begin
        g = 0;
        while (got_d.size() < 20 && g < 2000) begin
          @(negedge clk);
          g++;
        end
        #1 rst = 1'b1;
        #1;
        n_total++;
        if ({m_tvalid, m_tuser, m_tlast} !== 3'b000 || m_tdata !== 8'h00)
          $display("FAIL midreset_m_axis: got v/u/l=%b data=%h want 000/00", {m_tvalid, m_tuser, m_tlast}, m_tdata);
        else n_pass++;
        n_total++;
        if (s_tready !== 1'b0 || busy !== 1'b0)
          $display("FAIL midreset_ready_busy: got %b%b want 00", s_tready, busy);
        else n_pass++;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    lasts = 0;
    foreach (got_l[k]) if (got_l[k]) lasts++;
    n_total++;
    if (lasts != 0 || got_d.size() < 20) $display("FAIL midreset_aborted: got %0d tlast in %0d bytes want 0 in >=20", lasts, got_d.size());
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    clear_all();
    pl = rand_payload(28);
    add_expected(48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0806, pl);
    send_payload(pl, 0, 48'hFFFF_FFFF_FFFF, 48'h000A_3501_0203, 16'h0806, sent);
    s_tvalid = 1'b0;
    wait_out(60);
    dff = first_diff();
    n_total++;
    if (dff !== -1) $display("FAIL postreset_content: first diff at byte %0d (got %0d bytes)", dff, got_d.size());
    else n_pass++;
  endtask

  task automatic test_random();
    byte_q_t pl;
    int sent, tot_sent, tot_len, len, dff;
    logic [47:0] d, s;
    logic [15:0] t;
    clear_all();
    rdy_pct = 60;
    tot_sent = 0; tot_len = 0;
    for (int f = 0; f < 6; f++) begin
      len = (f == 0) ? 1 : $urandom_range(1, 120);
      tot_len += len;
      pl = rand_payload(len);
      d = {16'($urandom), $urandom};
      s = {16'($urandom), $urandom};
      t = ($urandom_range(0, 1) == 0) ? 16'h0800 : 16'h0806;
      add_expected(d, s, t, pl);
      send_payload(pl, 30, d, s, t, sent);
      tot_sent += sent;
    end
    s_tvalid = 1'b0;
    wait_out(exp_d.size());
    dff = first_diff();
    n_total++;
    if (dff !== -1) $display("FAIL random_content: first diff at byte %0d (got %0d want %0d bytes)", dff, got_d.size(), exp_d.size());
    else n_pass++;
    n_total++;
    if (tot_sent != tot_len) $display("FAIL random_accepted: got %0d want %0d", tot_sent, tot_len);
    else n_pass++;
    n_total++;
    if (stab_viol != 0 || rdy_viol != 0) $display("FAIL random_protocol: got stab=%0d rdy=%0d want 0/0", stab_viol, rdy_viol);
    else n_pass++;
    rdy_pct = 100;
  endtask

  initial begin
    s_tvalid = 1'b0; s_tdata = 8'h00; s_tuser = 1'b0; s_tlast = 1'b0;
    dmac = 48'h0; smac = 48'h0; etype = 16'h0;
    test_reset();
    test_arp();
    test_min_boundary();
    test_backpressure();
    test_src_gaps();
    test_back_to_back();
    test_idle_no_sof();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
